// File: rtl/sync_handshake_pulse.sv
// sync_handshake_pulse: single-clock toggle/handshake pulse generator.
// A source request flips a toggle. The toggle runs through a forward
// synchronizer chain and comes out as a one-cycle destination pulse. The
// acknowledge runs back through a return chain, and sRDY stays low until the
// acknowledge arrives. The data register paired with this block therefore
// holds steady for at least the synchronizer depth before the destination
// samples it.
// Optional feature: define SYNC_HANDSHAKE_ERR_EN to add the sticky sERR
// output. sERR flags a request made while the block is busy.
module sync_handshake_pulse #(
    parameter logic        init        = 1'b0,
    parameter logic        delayreturn = 1'b1,
    parameter int unsigned stages      = 2
) (
    input  logic sCLK,
    input  logic sRST,
    input  logic sEN,
    output logic sRDY,
`ifdef SYNC_HANDSHAKE_ERR_EN
    output logic sERR,
`endif
    output logic dPulse
);

    logic              s_toggle_q;
    logic              s_toggle_d;
    logic [stages-1:0] d_sync_q;
    logic [stages-1:0] d_sync_d;
    logic              d_last_q;
    logic              d_last_d;
    logic [stages-1:0] s_sync_q;
    logic [stages-1:0] s_sync_d;
    logic              accept_c;
    logic              ret_src_c;

    // Ready when the returned toggle has caught up with the source toggle.
    assign sRDY     = (s_sync_q[stages-1] == s_toggle_q);
    // Pulse while the synchronized toggle differs from its delayed copy.
    assign dPulse   = d_sync_q[stages-1] ^ d_last_q;
    // A request counts only while idle; busy requests are dropped.
    assign accept_c = sEN & sRDY;

    // Next-state: toggle on accept, shift both synchronizer chains.
    always_comb begin
        s_toggle_d = s_toggle_q ^ accept_c;
        d_sync_d   = {d_sync_q[stages-2:0], s_toggle_q};
        d_last_d   = d_sync_q[stages-1];
        // Taking the ack from dLast adds one cycle of margin past the pulse.
        ret_src_c  = delayreturn ? d_last_q : d_sync_q[stages-1];
        s_sync_d   = {s_sync_q[stages-2:0], ret_src_c};
    end

    // State registers; reset forces every bit to init, aborting any transfer.
    always_ff @(posedge sCLK or posedge sRST) begin
        if (sRST) begin
            s_toggle_q <= init;
            d_sync_q   <= {stages{init}};
            d_last_q   <= init;
            s_sync_q   <= {stages{init}};
        end else begin
            s_toggle_q <= s_toggle_d;
            d_sync_q   <= d_sync_d;
            d_last_q   <= d_last_d;
            s_sync_q   <= s_sync_d;
        end
    end

`ifdef SYNC_HANDSHAKE_ERR_EN
    logic s_err_q;
    logic s_err_d;

    // Sticky flag: set by any request made while busy.
    always_comb begin
        s_err_d = s_err_q | (sEN & ~sRDY);
    end

    // Error flag register; only reset clears it.
    always_ff @(posedge sCLK or posedge sRST) begin
        if (sRST) begin
            s_err_q <= 1'b0;
        end else begin
            s_err_q <= s_err_d;
        end
    end

    assign sERR = s_err_q;
`endif

endmodule

// File: tb/tb_sync_handshake_pulse.sv
// Testbench for sync_handshake_pulse. It drives three configurations side by
// side: defaults, delayreturn=0, and stages=3. Each instance is checked
// against a timing model of the handshake.
module tb_sync_handshake_pulse;

    localparam int NCFG = 3;
    localparam int S  [NCFG] = '{2, 2, 3};
    localparam int DR [NCFG] = '{1, 0, 1};

    logic            sCLK;
    logic            sRST;
    logic [NCFG-1:0] en;
    logic [NCFG-1:0] rdy;
    logic [NCFG-1:0] pls;
`ifdef SYNC_HANDSHAKE_ERR_EN
    logic [NCFG-1:0] err;
    logic [NCFG-1:0] m_err;
`endif

    // Model state: an edge counter, the first edge each instance can accept
    // on, and a queue holding the edge of every pulse still expected.
    int edge_idx;
    int rdy_at [NCFG];
    int exp_q  [NCFG][$];

    int n_tests;
    int n_fail;
    int pc [NCFG];
    int free_req;
    int free_seen;
    bit started;
    bit done;

    sync_handshake_pulse #(.init(1'b0), .delayreturn(1'b1), .stages(2)) u_dut0 (
        .sCLK(sCLK), .sRST(sRST), .sEN(en[0]), .sRDY(rdy[0]),
`ifdef SYNC_HANDSHAKE_ERR_EN
        .sERR(err[0]),
`endif
        .dPulse(pls[0]));

    sync_handshake_pulse #(.init(1'b0), .delayreturn(1'b0), .stages(2)) u_dut1 (
        .sCLK(sCLK), .sRST(sRST), .sEN(en[1]), .sRDY(rdy[1]),
`ifdef SYNC_HANDSHAKE_ERR_EN
        .sERR(err[1]),
`endif
        .dPulse(pls[1]));

    sync_handshake_pulse #(.init(1'b0), .delayreturn(1'b1), .stages(3)) u_dut2 (
        .sCLK(sCLK), .sRST(sRST), .sEN(en[2]), .sRDY(rdy[2]),
`ifdef SYNC_HANDSHAKE_ERR_EN
        .sERR(err[2]),
`endif
        .dPulse(pls[2]));

    initial sCLK = 1'b0;
    always #5 sCLK = ~sCLK;

    // Timing model. An accept at edge k expects a pulse at edge k+S, and the
    // instance is ready again after edge k+2S+DR.
    always @(posedge sCLK or posedge sRST) begin
        if (sRST) begin
            edge_idx = 0;
            for (int i = 0; i < NCFG; i++) begin
                rdy_at[i] = 0;
                exp_q[i].delete();
`ifdef SYNC_HANDSHAKE_ERR_EN
                m_err[i] = 1'b0;
`endif
            end
        end else begin
            for (int i = 0; i < NCFG; i++) begin
                if (en[i] === 1'b1) begin
                    if (edge_idx >= rdy_at[i]) begin
                        exp_q[i].push_back(edge_idx + S[i]);
                        rdy_at[i] = edge_idx + 2 * S[i] + DR[i] + 1;
                    end else begin
`ifdef SYNC_HANDSHAKE_ERR_EN
                        m_err[i] = 1'b1;
`endif
                    end
                end
            end
            edge_idx = edge_idx + 1;
        end
    end

    // Monitor: check every instance after each clock and on every reset
    // assertion.
    initial begin
        int  cur;
        int  exp_cnt;
        int  per;
        logic exp_r;
        logic exp_p;
        forever begin
            @(negedge sCLK or posedge sRST);
            #1;
            if (sRST) begin
                for (int i = 0; i < NCFG; i++) pc[i] = 0;
            end
            if (started) begin
                cur = edge_idx - 1;
                for (int i = 0; i < NCFG; i++) begin
                    exp_r = (edge_idx >= rdy_at[i]);
                    n_tests++;
                    if (rdy[i] !== exp_r) begin
                        n_fail++;
                        $display("FAIL srdy cfg%0d edge %0d: got %b expected %b", i, cur, rdy[i], exp_r);
                    end
                    exp_p = (exp_q[i].size() > 0) && (exp_q[i][0] == cur);
                    n_tests++;
                    if (pls[i] !== exp_p) begin
                        n_fail++;
                        $display("FAIL dpulse cfg%0d edge %0d: got %b expected %b", i, cur, pls[i], exp_p);
                    end
                    if (exp_p) void'(exp_q[i].pop_front());
                    if (pls[i] === 1'b1) pc[i]++;
`ifdef SYNC_HANDSHAKE_ERR_EN
                    n_tests++;
                    if (err[i] !== m_err[i]) begin
                        n_fail++;
                        $display("FAIL serr cfg%0d edge %0d: got %b expected %b", i, cur, err[i], m_err[i]);
                    end
`endif
                end
                if (free_req != free_seen) begin
                    free_seen = free_req;
                    for (int i = 0; i < NCFG; i++) begin
                        per = 2 * S[i] + DR[i] + 1;
                        exp_cnt = 0;
                        for (int k = 0; k * per + S[i] < 60; k++) exp_cnt++;
                        n_tests++;
                        if (pc[i] != exp_cnt) begin
                            n_fail++;
                            $display("FAIL freerun_count cfg%0d: got %0d pulses expected %0d", i, pc[i], exp_cnt);
                        end
                    end
                end
                if (done) begin
                    for (int i = 0; i < NCFG; i++) begin
                        n_tests++;
                        if (exp_q[i].size() != 0) begin
                            n_fail++;
                            $display("FAIL outstanding cfg%0d: got %0d pulses pending expected 0", i, exp_q[i].size());
                        end
                    end
                    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                    $finish;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sCLK);
    endtask

    // Assert reset partway through a low phase, hold it, then release on a negedge.
    task automatic do_reset(input int hold);
        @(negedge sCLK);
        #2;
        sRST = 1'b1;
        en   = '0;
        repeat (hold) @(negedge sCLK);
        sRST = 1'b0;
    endtask

    // Stimulus
    initial begin
        sRST      = 1'b1;
        en        = '0;
        started   = 1'b0;
        done      = 1'b0;
        free_req  = 0;
        free_seen = 0;
        n_tests   = 0;
        n_fail    = 0;
        repeat (3) @(negedge sCLK);
        sRST    = 1'b0;
        started = 1'b1;

        // One request on every instance
        cycles(3);
        en = '1;
        @(negedge sCLK);
        en = '0;
        cycles(12);

        // Reset asserted mid-cycle, then idle
        do_reset(2);
        cycles(10);

        // Accept at E0, then reset just after E1: the transfer is aborted
        @(negedge sCLK);
        en = '1;
        @(negedge sCLK);
        en = '0;
        do_reset(2);
        cycles(12);

        // Free-running loop for 60 edges with sEN tied to sRDY
        do_reset(2);
        en = rdy;
        repeat (59) begin
            @(negedge sCLK);
            en = rdy;
        end
        @(negedge sCLK);
        en = '0;
        free_req = free_req + 1;
        cycles(15);

        // sEN held high through busy periods
        en = '1;
        cycles(20);
        en = '0;
        cycles(15);

        // Random requests with an occasional reset
        for (int c = 0; c < 600; c++) begin
            @(negedge sCLK);
            en = NCFG'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end
        end
        en = '0;
        cycles(20);
        done = 1'b1;
        cycles(5);
        $display("FAIL monitor did not finish");
        $fatal(1, "monitor stalled");
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
